// File: rtl/vga_cursor_ctrl_pkg.sv
// Shared constants for the text-mode cursor controller: command codes,
// default geometry and the fixed widths of the position fields.
package vga_cursor_pkg;

  localparam int ADDR_W = 12;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 5;
  localparam int CMD_W  = 3;

  localparam int DEF_COLS         = 80;
  localparam int DEF_ROWS         = 30;
  localparam int DEF_TAB_W        = 8;
  localparam int DEF_BLINK_FRAMES = 16;

  localparam logic [CMD_W-1:0] CMD_NOP   = 3'd0;
  localparam logic [CMD_W-1:0] CMD_RIGHT = 3'd1;
  localparam logic [CMD_W-1:0] CMD_LEFT  = 3'd2;
  localparam logic [CMD_W-1:0] CMD_CR    = 3'd3;
  localparam logic [CMD_W-1:0] CMD_LF    = 3'd4;
  localparam logic [CMD_W-1:0] CMD_HOME  = 3'd5;
  localparam logic [CMD_W-1:0] CMD_SET   = 3'd6;
  localparam logic [CMD_W-1:0] CMD_TAB   = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } cur_state_e;

endpackage

// File: rtl/vga_cursor_ctrl_if.sv
// Command channel from the terminal front end into the cursor controller.
interface vga_cursor_ctrl_if;
  import vga_cursor_pkg::*;

  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [CMD_W-1:0] i_cmd;
  logic [COL_W-1:0] i_cmd_col;
  logic [ROW_W-1:0] i_cmd_row;

  modport master (
    output i_cmd_valid, i_cmd, i_cmd_col, i_cmd_row,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_cmd_col, i_cmd_row,
    output o_cmd_ready
  );

endinterface

// File: rtl/vga_cursor_ctrl_blink.sv
// Cursor blink phase: toggles every BLINK_FRAMES frame pulses, forced on by clr.
module vga_cursor_blink #(
  parameter int BLINK_FRAMES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_frame_start,
  input  logic i_clr,
  output logic o_phase
);

  localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] frame_cnt;
  logic             phase;

  // Host activity keeps the cursor solid, so clr outranks a same-cycle frame pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      frame_cnt <= '0;
      phase     <= 1'b1;
    end else if (i_clr) begin
      frame_cnt <= '0;
      phase     <= 1'b1;
    end else if (i_frame_start) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign o_phase = phase;

endmodule

// File: rtl/vga_cursor_ctrl.sv
// Cursor position controller: tracks col/row and the linear address row*COLS+col,
// updated incrementally for moves and by a shift-free repeated add for SET.
module vga_cursor_ctrl
  import vga_cursor_pkg::*;
#(
  parameter int COLS         = DEF_COLS,
  parameter int ROWS         = DEF_ROWS,
  parameter int TAB_W        = DEF_TAB_W,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  vga_cursor_ctrl_if.slave  cmd_if,
  input  logic              i_frame_start,
  input  logic              i_cursor_en,
  output logic [ADDR_W-1:0] o_cur_pos_addr,
  output logic [COL_W-1:0]  o_cur_col,
  output logic [ROW_W-1:0]  o_cur_row,
  output logic              o_scroll_req,
  output logic              o_cursor_vis
);

  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W:0]    TAB_MASK = (COL_W + 1)'(TAB_W - 1);
  localparam logic [COL_W:0]    COLS_X   = (COL_W + 1)'(COLS);

  function automatic logic [COL_W-1:0] clamp_col(input logic [COL_W-1:0] c);
    return (c > LAST_COL) ? LAST_COL : c;
  endfunction

  function automatic logic [ROW_W-1:0] clamp_row(input logic [ROW_W-1:0] r);
    return (r > LAST_ROW) ? LAST_ROW : r;
  endfunction

  cur_state_e state_q, state_d;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;
  logic              scroll;
  logic [COL_W-1:0]  tgt_col;
  logic [ROW_W-1:0]  tgt_row;
  logic [ROW_W-1:0]  calc_cnt;
  logic [ADDR_W-1:0] acc;
  logic              accept;
  logic              calc_done;
  logic              blink_phase;

  logic [ADDR_W-1:0] col_ext;
  logic [COL_W:0]    tab_col;
  logic              at_last_col;
  logic              at_last_row;

  assign accept      = cmd_if.i_cmd_valid & cmd_if.o_cmd_ready;
  assign calc_done   = (state_q == ST_CALC) && (calc_cnt == '0);
  assign col_ext     = ADDR_W'(col);
  assign tab_col     = ({1'b0, col} | TAB_MASK) + 1'b1;
  assign at_last_col = (col == LAST_COL);
  assign at_last_row = (row == LAST_ROW);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && cmd_if.i_cmd == CMD_SET) state_d = ST_CALC;
      ST_CALC: if (calc_cnt == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_if.o_cmd_ready = (state_q == ST_IDLE);
  end

  // SET: one COLS add per target row, then the column is folded in on exit.
  always_ff @(posedge i_clk) begin
    if (accept && cmd_if.i_cmd == CMD_SET) begin
      tgt_col  <= clamp_col(cmd_if.i_cmd_col);
      tgt_row  <= clamp_row(cmd_if.i_cmd_row);
      calc_cnt <= clamp_row(cmd_if.i_cmd_row);
      acc      <= '0;
    end else if (state_q == ST_CALC && calc_cnt != '0) begin
      acc      <= acc + COLS_A;
      calc_cnt <= calc_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      col    <= '0;
      row    <= '0;
      addr   <= '0;
      scroll <= 1'b0;
    end else begin
      scroll <= 1'b0;
      if (calc_done) begin
        col  <= tgt_col;
        row  <= tgt_row;
        addr <= acc + ADDR_W'(tgt_col);
      end else if (accept) begin
        case (cmd_if.i_cmd)
          CMD_RIGHT: begin
            if (!at_last_col) begin
              col  <= col + 1'b1;
              addr <= addr + 1'b1;
            end else if (!at_last_row) begin
              col  <= '0;
              row  <= row + 1'b1;
              addr <= addr + 1'b1;
            end else begin
              col    <= '0;
              addr   <= addr - ADDR_W'(LAST_COL);
              scroll <= 1'b1;
            end
          end
          CMD_LEFT: begin
            if (col != '0) begin
              col  <= col - 1'b1;
              addr <= addr - 1'b1;
            end else if (row != '0) begin
              col  <= LAST_COL;
              row  <= row - 1'b1;
              addr <= addr - 1'b1;
            end
          end
          CMD_CR: begin
            col  <= '0;
            addr <= addr - col_ext;
          end
          CMD_LF: begin
            if (!at_last_row) begin
              row  <= row + 1'b1;
              addr <= addr + COLS_A;
            end else begin
              scroll <= 1'b1;
            end
          end
          CMD_HOME: begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
          end
          CMD_TAB: begin
            // A tab past the last stop wraps exactly like RIGHT at the last column.
            if (tab_col < COLS_X) begin
              col  <= tab_col[COL_W-1:0];
              addr <= addr + ADDR_W'(tab_col) - col_ext;
            end else if (!at_last_row) begin
              col  <= '0;
              row  <= row + 1'b1;
              addr <= addr - col_ext + COLS_A;
            end else begin
              col    <= '0;
              addr   <= addr - col_ext;
              scroll <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  vga_cursor_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_frame_start (i_frame_start),
    .i_clr         (accept && cmd_if.i_cmd != CMD_NOP),
    .o_phase       (blink_phase)
  );

  assign o_cur_pos_addr = addr;
  assign o_cur_col      = col;
  assign o_cur_row      = row;
  assign o_scroll_req   = scroll;
  assign o_cursor_vis   = i_cursor_en & blink_phase;

endmodule
